duty_cycle_monitor: RTL and testbench
=====================================

// Module: duty_cycle_monitor
// PURPOSE
//  Consumer of the divide-by-2 output: samples a slow divided clock as data in the fast
//  clock domain and measures high time, low time and period per cycle in clock cycles.
//  Flags duty cycle within tolerance (50% check) and detects a stuck or non-toggling
//  input. Used as a built-in checker on the divider stage.
// PARAMETERS
//  CNT_W        8    width of high/low counters; period is CNT_W+1 bits
//  TOL          1    max allowed |high_cnt - low_cnt| for duty_ok
//  TIMEOUT      255  cycles at one level before stuck; must be <= 2**CNT_W-1
//  SYNC_STAGES  2    synchronizer depth for sig_in (>=2)
// PORTS
//  clock       in   1        fast sampling clock, all logic on posedge
//  reset       in   1        synchronous, active-high
//  sig_in      in   1        monitored divided clock (async to clock)
//  enable      in   1        1 = measure; 0 = return to ARM, clear counters
//  high_cnt    out  CNT_W    cycles high in last complete period
//  low_cnt     out  CNT_W    cycles low in last complete period
//  period      out  CNT_W+1  high_cnt + low_cnt
//  meas_valid  out  1        1-cycle pulse when outputs update
//  duty_ok     out  1        |high_cnt-low_cnt| <= TOL for last measurement
//  stuck       out  1        sticky: no edge within TIMEOUT cycles
//  stuck_level out  1        synced sig_in level when stuck set
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, FSM ARM, sync chain and prev-level flop 0.
//  Sync: sig_in -> SYNC_STAGES flops -> s; prev flop p. rise = s&~p, fall = ~s&p.
//  FSM states: ARM, MEAS_HIGH, MEAS_LOW.
//   ARM: counters held 0; on rise -> MEAS_HIGH, hcnt=1 (edge cycle counts).
//   MEAS_HIGH: hcnt++ each cycle s=1; on fall -> MEAS_LOW, lcnt=1.
//   MEAS_LOW: lcnt++ each cycle s=0; on rise -> register high_cnt=hcnt,
//    low_cnt=lcnt, period=hcnt+lcnt (CNT_W+1 bits, no overflow), duty_ok;
//    meas_valid=1 next cycle with new values; hcnt=1, lcnt=0, -> MEAS_HIGH.
//  First period after ARM produces no meas_valid until a full high+low+rise seen.
//  Outputs hold between updates; meas_valid 0 otherwise.
//  Latency: sig_in rise to meas_valid = SYNC_STAGES+1 clock edges after capture.
//  Timeout: in MEAS_HIGH/MEAS_LOW, if active counter == TIMEOUT and no edge this
//   cycle: stuck=1, stuck_level=s, -> ARM. Also from ARM: idle counter reaching
//   TIMEOUT with no rise sets stuck. Counters never wrap (TIMEOUT bounds them).
//  stuck clears only on reset or on next meas_valid.
//  Edge and timeout same cycle: edge wins.
//  enable=0: -> ARM next cycle, counters 0, no meas_valid, outputs/stuck hold.
//  Reset mid-measurement: immediate return to reset state, partial count discarded.
//  duty_ok: compare with subtraction in CNT_W+1 bits, abs value, <= TOL.
// STRUCTURE
//  Package duty_mon_pkg: state enum (ARM, MEAS_HIGH, MEAS_LOW), CNT_W default const.
//  Sub-module sync_edge_detect: SYNC_STAGES sync + prev flop, outputs s, rise, fall.
//  Top: FSM, hcnt/lcnt/idle counters, result registers, compare.
// TESTING
//  1 sig_in 4 high/4 low synced to clock, 3 periods -> high=4 low=4 period=8
//    duty_ok=1, meas_valid once per period, first after 2nd rise.
//  2 sig_in 5 high/3 low, TOL=1 -> high=5 low=3 period=8 duty_ok=0.
//  3 sig_in held 1 after first rise -> stuck=1 stuck_level=1 after TIMEOUT cycles,
//    FSM ARM; resume 4/4 toggling -> stuck clears on next meas_valid.
//  4 enable dropped mid MEAS_LOW for 3 cycles -> no meas_valid, outputs hold;
//    re-enable -> first valid only after a full new period.
//  5 reset asserted mid MEAS_HIGH -> all outputs 0 next cycle, stuck=0, state ARM.
//  6 drive from divide-by-2 of clock/4 source (period 8) -> high=4 low=4 continuous.

Source files
------------

// File: rtl/duty_mon_pkg.sv
// rtl/duty_mon_pkg.sv - shared types and defaults for the duty cycle monitor
//  Contents:
//   CNT_W_DEF    default width of the high/low/idle counters
//   mon_state_t  measurement FSM states (ARM, MEAS_HIGH, MEAS_LOW)
package duty_mon_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ARM       = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - input synchronizer with registered-level edge detect
//  Ports:
//   clock   in   sampling clock, posedge
//   reset   in   synchronous, active-high; clears sync chain and prev flop
//   sig_in  in   asynchronous level to be sampled
//   s       out  synchronized level (last sync stage)
//   rise    out  s went 0->1 this cycle
//   fall    out  s went 1->0 this cycle
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev_q;
  assign fall = ~s & prev_q;

endmodule

// File: rtl/duty_cycle_monitor.sv
// rtl/duty_cycle_monitor.sv - measures high/low time of a slow sampled clock
//  Ports:
//   clock        in   fast sampling clock, posedge
//   reset        in   synchronous, active-high
//   sig_in       in   monitored divided clock (asynchronous)
//   enable       in   1 = measure, 0 = return to ARM with counters cleared
//   high_cnt     out  cycles high in last complete period
//   low_cnt      out  cycles low in last complete period
//   period       out  high_cnt + low_cnt (one bit wider)
//   meas_valid   out  one-cycle pulse when the result registers update
//   duty_ok      out  |high_cnt - low_cnt| <= TOL for last measurement
//   stuck        out  sticky: no edge seen within TIMEOUT cycles
//   stuck_level  out  synchronized level captured when stuck was set
module duty_cycle_monitor
  import duty_mon_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TOL         = 1,
  parameter int TIMEOUT     = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] low_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             duty_ok,
  output logic             stuck,
  output logic             stuck_level
);

  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0] ONE_V     = CNT_W'(1);

  logic s;
  logic rise;
  logic fall;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clock  (clock),
    .reset  (reset),
    .sig_in (sig_in),
    .s      (s),
    .rise   (rise),
    .fall   (fall)
  );

  mon_state_t       state_q;
  mon_state_t       state_d;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] lcnt;
  logic [CNT_W-1:0] idle;

  // Per-cycle control strobes decoded from the state and edges
  logic go_high;
  logic go_low;
  logic do_meas;
  logic inc_high;
  logic inc_low;
  logic inc_idle;
  logic timeout;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARM;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic; an edge always wins over a timeout in the same cycle
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ARM;
    end else begin
      case (state_q)
        ARM: begin
          if (rise) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (fall)                    state_d = MEAS_LOW;
          else if (hcnt == TIMEOUT_V)  state_d = ARM;
        end
        MEAS_LOW: begin
          if (rise)                    state_d = MEAS_HIGH;
          else if (lcnt == TIMEOUT_V)  state_d = ARM;
        end
        default: state_d = ARM;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output (strobe) decode
  // ---------------------------------------------------------------------
  always_comb begin
    go_high  = 1'b0;
    go_low   = 1'b0;
    do_meas  = 1'b0;
    inc_high = 1'b0;
    inc_low  = 1'b0;
    inc_idle = 1'b0;
    timeout  = 1'b0;
    if (enable) begin
      case (state_q)
        ARM: begin
          go_high  = rise;
          inc_idle = !rise && (idle != TIMEOUT_V);
          timeout  = !rise && (idle == TIMEOUT_V);
        end
        MEAS_HIGH: begin
          go_low   = fall;
          inc_high = !fall && (hcnt != TIMEOUT_V);
          timeout  = !fall && (hcnt == TIMEOUT_V);
        end
        MEAS_LOW: begin
          go_high  = rise;
          do_meas  = rise;
          inc_low  = !rise && (lcnt != TIMEOUT_V);
          timeout  = !rise && (lcnt == TIMEOUT_V);
        end
        default: begin
          go_high = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Counters. The edge cycle itself counts as the first cycle of a level,
  // so a new level starts its counter at 1. TIMEOUT bounds every counter,
  // so no wrap is possible.
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset || !enable || timeout) begin
      hcnt <= '0;
      lcnt <= '0;
      idle <= '0;
    end else begin
      if (go_high) begin
        hcnt <= ONE_V;
        lcnt <= '0;
        idle <= '0;
      end
      if (go_low)   lcnt <= ONE_V;
      if (inc_high) hcnt <= hcnt + ONE_V;
      if (inc_low)  lcnt <= lcnt + ONE_V;
      if (inc_idle) idle <= idle + ONE_V;
    end
  end

  // ---------------------------------------------------------------------
  // Result compare: widen by one bit so the difference carries its sign
  // ---------------------------------------------------------------------
  logic [CNT_W:0] sum_w;
  logic [CNT_W:0] diff_w;
  logic [CNT_W:0] abs_w;
  logic           within_tol;

  always_comb begin
    sum_w      = {1'b0, hcnt} + {1'b0, lcnt};
    diff_w     = {1'b0, hcnt} - {1'b0, lcnt};
    abs_w      = diff_w[CNT_W] ? ((CNT_W+1)'(0) - diff_w) : diff_w;
    within_tol = (abs_w <= TOL_V);
  end

  // ---------------------------------------------------------------------
  // Result registers; held between measurements and across enable=0
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      high_cnt    <= '0;
      low_cnt     <= '0;
      period      <= '0;
      meas_valid  <= 1'b0;
      duty_ok     <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= do_meas;
      if (do_meas) begin
        high_cnt <= hcnt;
        low_cnt  <= lcnt;
        period   <= sum_w;
        duty_ok  <= within_tol;
        stuck    <= 1'b0;
      end else if (timeout) begin
        stuck       <= 1'b1;
        stuck_level <= s;
      end
    end
  end

endmodule

// File: tb/tb_duty_cycle_monitor.sv
// tb/tb_duty_cycle_monitor.sv - directed self-checking bench for duty_cycle_monitor
module tb_duty_cycle_monitor;
  import duty_mon_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       sig_in;
  logic       enable;
  logic [7:0] high_cnt;
  logic [7:0] low_cnt;
  logic [8:0] period;
  logic       meas_valid;
  logic       duty_ok;
  logic       stuck;
  logic       stuck_level;

  int         nchecks = 0;
  int         nerrors = 0;
  int         vcnt    = 0;
  logic [7:0] last_h;
  logic [7:0] last_l;
  logic [8:0] last_p;
  logic       last_ok;

  duty_cycle_monitor #(
    .CNT_W       (8),
    .TOL         (1),
    .TIMEOUT     (255),
    .SYNC_STAGES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .sig_in      (sig_in),
    .enable      (enable),
    .high_cnt    (high_cnt),
    .low_cnt     (low_cnt),
    .period      (period),
    .meas_valid  (meas_valid),
    .duty_ok     (duty_ok),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #5 clock = ~clock;

  // One clock: drive sig_in just after the edge, sample at the falling edge
  task automatic cyc(input logic lvl);
    @(posedge clock);
    #1 sig_in = lvl;
    @(negedge clock);
    if (meas_valid === 1'b1) begin
      vcnt++;
      last_h  = high_cnt;
      last_l  = low_cnt;
      last_p  = period;
      last_ok = duty_ok;
    end
  endtask

  task automatic run(input logic lvl, input int n);
    for (int i = 0; i < n; i++) cyc(lvl);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    sig_in = 1'b0;
    enable = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    vcnt    = 0;
    last_h  = '0;
    last_l  = '0;
    last_p  = '0;
    last_ok = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    nchecks++; if (high_cnt !== 8'd0) begin nerrors++; $display("FAIL reset_high_cnt: got %0d want 0", high_cnt); end
    nchecks++; if (low_cnt !== 8'd0) begin nerrors++; $display("FAIL reset_low_cnt: got %0d want 0", low_cnt); end
    nchecks++; if (period !== 9'd0) begin nerrors++; $display("FAIL reset_period: got %0d want 0", period); end
    nchecks++; if (meas_valid !== 1'b0) begin nerrors++; $display("FAIL reset_meas_valid: got %b want 0", meas_valid); end
    nchecks++; if (duty_ok !== 1'b0) begin nerrors++; $display("FAIL reset_duty_ok: got %b want 0", duty_ok); end
    nchecks++; if (stuck !== 1'b0) begin nerrors++; $display("FAIL reset_stuck: got %b want 0", stuck); end
    nchecks++; if (stuck_level !== 1'b0) begin nerrors++; $display("FAIL reset_stuck_level: got %b want 0", stuck_level); end
    nchecks++; if (dut.state_q !== ARM) begin nerrors++; $display("FAIL reset_state: got %0d want ARM", dut.state_q); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_balanced();
    do_reset();
    run(0, 2);
    run(1, 4);
    run(0, 4);
    nchecks++; if (vcnt !== 0) begin nerrors++; $display("FAIL bal_first_period_no_valid: got %0d want 0", vcnt); end
    run(1, 4); run(0, 4);
    run(1, 4); run(0, 4);
    run(1, 5);
    nchecks++; if (vcnt !== 3) begin nerrors++; $display("FAIL bal_valid_count: got %0d want 3", vcnt); end
    nchecks++; if (last_h !== 8'd4) begin nerrors++; $display("FAIL bal_high: got %0d want 4", last_h); end
    nchecks++; if (last_l !== 8'd4) begin nerrors++; $display("FAIL bal_low: got %0d want 4", last_l); end
    nchecks++; if (last_p !== 9'd8) begin nerrors++; $display("FAIL bal_period: got %0d want 8", last_p); end
    nchecks++; if (last_ok !== 1'b1) begin nerrors++; $display("FAIL bal_duty_ok: got %b want 1", last_ok); end
    nchecks++; if (meas_valid !== 1'b0) begin nerrors++; $display("FAIL bal_valid_is_pulse: got %b want 0", meas_valid); end
  endtask

  task automatic test_skewed();
    do_reset();
    run(0, 2);
    run(1, 5); run(0, 3);
    run(1, 5); run(0, 3);
    run(1, 4);
    nchecks++; if (vcnt !== 2) begin nerrors++; $display("FAIL skew_valid_count: got %0d want 2", vcnt); end
    nchecks++; if (last_h !== 8'd5) begin nerrors++; $display("FAIL skew_high: got %0d want 5", last_h); end
    nchecks++; if (last_l !== 8'd3) begin nerrors++; $display("FAIL skew_low: got %0d want 3", last_l); end
    nchecks++; if (last_p !== 9'd8) begin nerrors++; $display("FAIL skew_period: got %0d want 8", last_p); end
    nchecks++; if (last_ok !== 1'b0) begin nerrors++; $display("FAIL skew_duty_ok: got %b want 0", last_ok); end
    // 4 high / 3 low sits exactly on the tolerance
    run(0, 3);
    run(1, 4);
    nchecks++; if (vcnt !== 3) begin nerrors++; $display("FAIL tol_valid_count: got %0d want 3", vcnt); end
    nchecks++; if (last_h !== 8'd4 || last_l !== 8'd3) begin nerrors++; $display("FAIL tol_counts: got %0d/%0d want 4/3", last_h, last_l); end
    nchecks++; if (last_p !== 9'd7) begin nerrors++; $display("FAIL tol_period: got %0d want 7", last_p); end
    nchecks++; if (last_ok !== 1'b1) begin nerrors++; $display("FAIL tol_duty_ok: got %b want 1", last_ok); end
  endtask

  task automatic test_stuck();
    do_reset();
    run(0, 2);
    run(1, 250);
    nchecks++; if (stuck !== 1'b0) begin nerrors++; $display("FAIL stuck_early: got %b want 0", stuck); end
    run(1, 20);
    nchecks++; if (stuck !== 1'b1) begin nerrors++; $display("FAIL stuck_set: got %b want 1", stuck); end
    nchecks++; if (stuck_level !== 1'b1) begin nerrors++; $display("FAIL stuck_level: got %b want 1", stuck_level); end
    nchecks++; if (dut.state_q !== ARM) begin nerrors++; $display("FAIL stuck_state: got %0d want ARM", dut.state_q); end
    nchecks++; if (vcnt !== 0) begin nerrors++; $display("FAIL stuck_no_valid: got %0d want 0", vcnt); end
    run(0, 4); run(1, 4); run(0, 4);
    nchecks++; if (stuck !== 1'b1) begin nerrors++; $display("FAIL stuck_sticky: got %b want 1", stuck); end
    run(1, 4);
    nchecks++; if (vcnt !== 1) begin nerrors++; $display("FAIL stuck_resume_valid: got %0d want 1", vcnt); end
    nchecks++; if (stuck !== 1'b0) begin nerrors++; $display("FAIL stuck_cleared: got %b want 0", stuck); end
    nchecks++; if (last_h !== 8'd4 || last_l !== 8'd4) begin nerrors++; $display("FAIL stuck_resume_counts: got %0d/%0d want 4/4", last_h, last_l); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    run(0, 2);
    run(1, 4); run(0, 4);
    run(1, 4);
    nchecks++; if (vcnt !== 1) begin nerrors++; $display("FAIL en_pre_valid: got %0d want 1", vcnt); end
    run(0, 5);
    nchecks++; if (dut.state_q !== MEAS_LOW) begin nerrors++; $display("FAIL en_pre_state: got %0d want MEAS_LOW", dut.state_q); end
    enable = 1'b0;
    run(0, 3);
    nchecks++; if (dut.state_q !== ARM) begin nerrors++; $display("FAIL en_off_state: got %0d want ARM", dut.state_q); end
    enable = 1'b1;
    nchecks++; if (high_cnt !== 8'd4 || low_cnt !== 8'd4) begin nerrors++; $display("FAIL en_hold_counts: got %0d/%0d want 4/4", high_cnt, low_cnt); end
    nchecks++; if (duty_ok !== 1'b1) begin nerrors++; $display("FAIL en_hold_duty_ok: got %b want 1", duty_ok); end
    run(0, 2);
    run(1, 3); run(0, 5);
    nchecks++; if (vcnt !== 1) begin nerrors++; $display("FAIL en_no_early_valid: got %0d want 1", vcnt); end
    run(1, 4);
    nchecks++; if (vcnt !== 2) begin nerrors++; $display("FAIL en_post_valid: got %0d want 2", vcnt); end
    nchecks++; if (last_h !== 8'd3 || last_l !== 8'd5) begin nerrors++; $display("FAIL en_post_counts: got %0d/%0d want 3/5", last_h, last_l); end
    nchecks++; if (last_p !== 9'd8 || last_ok !== 1'b0) begin nerrors++; $display("FAIL en_post_result: got period %0d ok %b want 8 0", last_p, last_ok); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    run(0, 2);
    run(1, 4); run(0, 4);
    run(1, 6);
    nchecks++; if (high_cnt !== 8'd4 || duty_ok !== 1'b1) begin nerrors++; $display("FAIL rmid_pre: got %0d ok %b want 4 1", high_cnt, duty_ok); end
    nchecks++; if (dut.state_q !== MEAS_HIGH) begin nerrors++; $display("FAIL rmid_pre_state: got %0d want MEAS_HIGH", dut.state_q); end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    nchecks++; if (high_cnt !== 8'd0 || low_cnt !== 8'd0 || period !== 9'd0) begin nerrors++; $display("FAIL rmid_counts: got %0d/%0d/%0d want 0/0/0", high_cnt, low_cnt, period); end
    nchecks++; if (duty_ok !== 1'b0 || stuck !== 1'b0 || meas_valid !== 1'b0) begin nerrors++; $display("FAIL rmid_flags: got ok %b stuck %b valid %b want 0 0 0", duty_ok, stuck, meas_valid); end
    nchecks++; if (dut.state_q !== ARM) begin nerrors++; $display("FAIL rmid_state: got %0d want ARM", dut.state_q); end
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_divider_source();
    logic q4;
    logic q4_n;
    logic d2;
    do_reset();
    q4 = 1'b0;
    d2 = 1'b0;
    for (int i = 0; i < 88; i++) begin
      @(posedge clock);
      #1;
      if (i % 2 == 0) begin
        q4_n = ~q4;
        if (q4_n && !q4) d2 = ~d2;
        q4 = q4_n;
      end
      sig_in = d2;
      @(negedge clock);
      if (meas_valid === 1'b1) begin
        vcnt++;
        nchecks++; if (high_cnt !== 8'd4 || low_cnt !== 8'd4) begin nerrors++; $display("FAIL div_counts: got %0d/%0d want 4/4", high_cnt, low_cnt); end
        nchecks++; if (period !== 9'd8 || duty_ok !== 1'b1) begin nerrors++; $display("FAIL div_result: got period %0d ok %b want 8 1", period, duty_ok); end
      end
    end
    nchecks++; if (vcnt !== 10) begin nerrors++; $display("FAIL div_valid_count: got %0d want 10", vcnt); end
    nchecks++; if (stuck !== 1'b0) begin nerrors++; $display("FAIL div_stuck: got %b want 0", stuck); end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    enable = 1'b1;
    test_reset();
    test_balanced();
    test_skewed();
    test_stuck();
    test_enable_drop();
    test_reset_mid();
    test_divider_source();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
